uart_tx_fifo: RTL and testbench

Buffered, parametrised UART transmitter: accepts words on an AXI4-Stream slave into an internal synchronous FIFO and serialises them onto `txd` with configurable data width, optional parity and one or two stop bits. Sits between a bus-side register block or DMA stream and the pad. It is the next-generation drop-in for the unbuffered 8N1 transmitter: the same `prescale` semantics (bit period = `prescale`×8 clocks), plus queueing, frame-format control and fill-level status.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_sfifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Parity handling in the top level is enabled by UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVERSAMPLE = 8;

  // Bit-timer reload; prescale 0 behaves as 1, large values wrap silently.
  function automatic logic [31:0] bit_reload(input logic [31:0] ps);
    logic [31:0] p;
    p = (ps == 32'd0) ? 32'd1 : ps;
    return p * 32'(OVERSAMPLE) - 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sfifo.sv
// Synchronous FIFO feeding the UART serializer; ready is a registered not-full flag.
// Read-before-write: rd_data always presents the head entry.
module uart_tx_sfifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             ready,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_next;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + CW'(1);
    else if (do_pop && !do_push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      // A slot freed by a pop on a full FIFO shows up one cycle later.
      ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: AXI4-Stream slave -> FIFO -> serializer on txd.
// Define UART_TX_PARITY_EN to add the parity_mode port and the parity bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count,
  input  logic [31:0]           prescale,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]            parity_mode,
`endif
  input  logic                  stop2
);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] shreg;
  logic [31:0]           timer;
  logic [31:0]           reload;
  logic [3:0]            bit_cnt;
  logic                  stop2_q;
  logic                  stop_second;
  logic                  fifo_empty;
  logic                  bit_done;
  logic                  frame_end;
  logic                  pop;
`ifdef UART_TX_PARITY_EN
  logic                  par_en;
  logic                  par_bit;
`endif

  uart_tx_sfifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_axis_tvalid && s_axis_tready),
    .wr_data (s_axis_tdata),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .ready   (s_axis_tready),
    .count   (fifo_count)
  );

  assign bit_done  = (timer == 32'd0);
  assign frame_end = (state == ST_STOP) && bit_done && (!stop2_q || stop_second);
  assign pop       = !fifo_empty && ((state == ST_IDLE) || frame_end);
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      txd         <= 1'b1;
      timer       <= '0;
      reload      <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
`endif
    end else if (pop) begin
      // Shadow the word and frame format; the frame ignores later input changes.
      state       <= ST_START;
      txd         <= 1'b0;
      shreg       <= head;
      reload      <= bit_reload(prescale);
      timer       <= bit_reload(prescale);
      stop2_q     <= stop2;
      stop_second <= 1'b0;
      bit_cnt     <= '0;
`ifdef UART_TX_PARITY_EN
      par_en      <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_bit     <= (^head) ^ (parity_mode == PAR_ODD);
`endif
    end else if (state != ST_IDLE) begin
      if (!bit_done) begin
        timer <= timer - 32'd1;
      end else begin
        timer <= reload;
        case (state)
          ST_START: begin
            state <= ST_DATA;
            txd   <= shreg[0];
          end
          ST_DATA: begin
            if (bit_cnt != 4'(DATA_WIDTH - 1)) begin
              bit_cnt <= bit_cnt + 4'd1;
              txd     <= shreg[1];
              shreg   <= shreg >> 1;
            end
`ifdef UART_TX_PARITY_EN
            else if (par_en) begin
              state <= ST_PARITY;
              txd   <= par_bit;
            end
`endif
            else begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end
`endif
          ST_STOP: begin
            if (stop2_q && !stop_second) stop_second <= 1'b1;
            else                         state       <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queued words are scoreboarded against frames decoded from txd.
// Parity scenarios exist only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          txd;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [31:0]   prescale = 32'd1;
  logic          stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic [1:0]    parity_mode = 2'b00;
`endif

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .txd           (txd),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .prescale      (prescale),
`ifdef UART_TX_PARITY_EN
    .parity_mode   (parity_mode),
`endif
    .stop2         (stop2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            period;
    int            nstop;
    int            par;     // -1 = no parity bit expected
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   frames_started = 0;
  int   frames_done = 0;
  int   accept_cyc = 0;

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_slot(input int per, output logic val, output bit bad, output bit ab);
    val = txd; bad = 1'b0; ab = 1'b0;
    for (int k = 0; k < per; k++) begin
      if (k > 0) @(negedge clk);
      if (rst) begin ab = 1'b1; return; end
      if (txd !== val) bad = 1'b1;
    end
  endtask

  task automatic monitor_frame();
    exp_t          e;
    logic          v;
    bit            bad, ab, frame_bad;
    logic [DW-1:0] got;
    int            hi;
    frames_started++;
    start_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_frame: start bit at cycle %0d, required idle line", cyc);
      hi = 0;
      for (int k = 0; k < 5000 && hi < 40; k++) begin
        @(negedge clk);
        hi = (txd === 1'b1) ? hi + 1 : 0;
      end
      return;
    end
    e = exp_q.pop_front();
    frame_bad = 1'b0;
    got = '0;
    mon_slot(e.period, v, bad, ab);
    if (ab) return;
    frame_bad |= bad;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      mon_slot(e.period, v, bad, ab);
      if (ab) return;
      got[i] = v;
      frame_bad |= bad;
    end
    vectors++;
    if (got !== e.data) begin
      miscompares++;
      $display("FAIL frame_data: got %h, required %h", got, e.data);
    end
    if (e.par >= 0) begin
      @(negedge clk);
      mon_slot(e.period, v, bad, ab);
      if (ab) return;
      frame_bad |= bad;
      vectors++;
      if (v !== 1'(e.par)) begin
        miscompares++;
        $display("FAIL parity_bit: got %b, required %b (data %h)", v, 1'(e.par), e.data);
      end
    end
    for (int s = 0; s < e.nstop; s++) begin
      @(negedge clk);
      mon_slot(e.period, v, bad, ab);
      if (ab) return;
      frame_bad |= bad;
      vectors++;
      if (v !== 1'b1) begin
        miscompares++;
        $display("FAIL stop_bit: stop %0d got %b, required 1", s, v);
      end
    end
    vectors++;
    if (frame_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL bit_timing: got level change inside a bit (data %h), required each level held %0d clocks", e.data, e.period);
    end
    frames_done++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) monitor_frame();
    end
  end

  // ---------------- drivers ----------------
  task automatic push_word(input logic [DW-1:0] d, input int per, input int nstop, input int par);
    exp_t e;
    int   n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: tready got %b, required 1 within 3000 cycles", s_axis_tready);
      s_axis_tvalid = 1'b0;
      return;
    end
    e.data = d; e.period = per; e.nstop = nstop; e.par = par;
    exp_q.push_back(e);
    @(negedge clk);
    accept_cyc    = cyc;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (frames_done < target) begin
      miscompares++;
      $display("FAIL frame_wait: got %0d frames, required %0d", frames_done, target);
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b, required 1", txd); end
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b, required 0", s_axis_tready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL reset_release_tready: got %b, required 1", s_axis_tready); end
  endtask

  task automatic test_single();
    int base = frames_done;
    int acc;
    start_q.delete();
    prescale = 32'd1; stop2 = 1'b0;
    push_word(8'hA5, 8, 1, -1);
    acc = accept_cyc;
    vectors++; if (fifo_count !== CW'(1)) begin miscompares++; $display("FAIL single_count_after_push: got %0d, required 1", fifo_count); end
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL single_txd_before_pop: got %b, required 1", txd); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_queued: got %b, required 1", busy); end
    @(negedge clk);
    vectors++; if (txd !== 1'b0) begin miscompares++; $display("FAIL single_start_edge: got %b, required 0", txd); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL single_count_after_pop: got %0d, required 0", fifo_count); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_frame: got %b, required 1", busy); end
    wait_frames(base + 1, 400);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL single_idle_txd: got %b, required 1", txd); end
    vectors++;
    if (start_q.size() != 1 || start_q[0] - acc != 1) begin
      miscompares++;
      $display("FAIL single_start_latency: got %0d starts, first at +%0d, required 1 start at +1",
               start_q.size(), (start_q.size() > 0) ? start_q[0] - acc : -1);
    end
  endtask

  task automatic test_burst();
    int base = frames_done;
    start_q.delete();
    prescale = 32'd1; stop2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push_word(8'(i * 37 + 5), 8, 1, -1);
      if (i >= 16) begin
        vectors++; if (fifo_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL burst_count_full: word %0d got %0d, required %0d", i, fifo_count, DEPTH); end
        vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL burst_tready_full: word %0d got %b, required 0", i, s_axis_tready); end
      end
    end
    wait_frames(base + 20, 3000);
    vectors++;
    if (start_q.size() != 20) begin
      miscompares++;
      $display("FAIL burst_frame_count: got %0d, required 20", start_q.size());
    end else begin
      for (int i = 0; i < 19; i++) begin
        vectors++;
        if (start_q[i+1] - start_q[i] != 80) begin
          miscompares++;
          $display("FAIL burst_gap: frame %0d spacing got %0d, required 80", i, start_q[i+1] - start_q[i]);
        end
      end
    end
  endtask

  task automatic test_stop2();
    int base = frames_done;
    start_q.delete();
    prescale = 32'd1; stop2 = 1'b1;
    push_word(8'h3C, 8, 2, -1);
    push_word(8'hC3, 8, 2, -1);
    wait_frames(base + 2, 600);
    stop2 = 1'b0;
    vectors++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 88) begin
      miscompares++;
      $display("FAIL stop2_gap: got %0d starts, spacing %0d, required 2 starts spacing 88",
               start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  function automatic int exp_parity(input logic [DW-1:0] d, input logic [1:0] mode);
    if (mode == 2'b01) return int'(^d);
    if (mode == 2'b10) return int'(~(^d));
    return -1;
  endfunction

  task automatic test_parity();
    int base = frames_done;
    start_q.delete();
    prescale = 32'd1; stop2 = 1'b0;
    parity_mode = 2'b10;
    push_word(8'h07, 8, 1, exp_parity(8'h07, 2'b10));
    push_word(8'h5A, 8, 1, exp_parity(8'h5A, 2'b10));
    wait_frames(base + 2, 600);
    vectors++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 88) begin
      miscompares++;
      $display("FAIL parity_frame_len: got %0d starts, spacing %0d, required 2 starts spacing 88",
               start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1);
    end
    parity_mode = 2'b01;
    push_word(8'h07, 8, 1, exp_parity(8'h07, 2'b01));
    wait_frames(base + 3, 400);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_even_end_busy: got %b, required 0", busy); end
    parity_mode = 2'b11;
    push_word(8'h07, 8, 1, -1);
    wait_frames(base + 4, 400);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_none_end_busy: got %b, required 0", busy); end
    parity_mode = 2'b00;
  endtask
`endif

  task automatic test_prescale();
    int base = frames_done;
    start_q.delete();
    prescale = 32'd1; stop2 = 1'b0;
    push_word(8'h96, 8, 1, -1);
    repeat (20) @(negedge clk);
    prescale = 32'd4;
    push_word(8'h69, 32, 1, -1);
    wait_frames(base + 2, 1000);
    vectors++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 80) begin
      miscompares++;
      $display("FAIL prescale_midframe: got %0d starts, spacing %0d, required 2 starts spacing 80",
               start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : -1);
    end
    prescale = 32'd0;
    push_word(8'h5A, 8, 1, -1);
    wait_frames(base + 3, 400);
    prescale = 32'd1;
  endtask

  task automatic test_reset_mid();
    int started;
    bit hi;
    prescale = 32'd1; stop2 = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'hE1 + i), 8, 1, -1);
    repeat (20) @(negedge clk);
    vectors++; if (fifo_count !== CW'(3)) begin miscompares++; $display("FAIL midrst_queued: got %0d, required 3", fifo_count); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL midrst_txd: got %b, required 1", txd); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL midrst_count: got %0d, required 0", fifo_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL midrst_tready: got %b, required 0", s_axis_tready); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL midrst_tready_release: got %b, required 1", s_axis_tready); end
    started = frames_started;
    hi = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (txd !== 1'b1) hi = 1'b0;
    end
    vectors++; if (frames_started != started) begin miscompares++; $display("FAIL midrst_no_frames: got %0d new frames, required 0", frames_started - started); end
    vectors++; if (hi !== 1'b1) begin miscompares++; $display("FAIL midrst_line_idle: got low level after reset, required constant 1"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got past 50000 cycles, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_prescale();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d unsent words, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
